// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 8-bit-instruction core: opcode and format
// encodings, the sequencer state type, and opcode classification helpers used
// by both the instruction ROM decoder and core_sequencer.
// -----------------------------------------------------------------------------
package core_pkg;

    // Opcode encodings (4-bit)
    localparam logic [3:0] OP_LB   = 4'h0;
    localparam logic [3:0] OP_LHB  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_LIM  = 4'h3;
    localparam logic [3:0] OP_MVB  = 4'h4;
    localparam logic [3:0] OP_MVF  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_SFT  = 4'h8;
    localparam logic [3:0] OP_INC  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_BLT  = 4'hD;
    localparam logic [3:0] OP_TBA  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction formats (2-bit)
    typedef enum logic [1:0] {
        FMT_C = 2'd0,
        FMT_I = 2'd1,
        FMT_M = 2'd2,
        FMT_X = 2'd3
    } fmt_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_t;

    // Instructions that need a data-memory phase between EXEC and WB.
    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_LB, OP_LHB, OP_STR: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    // Instructions that write the register file in WB.
    function automatic logic writes_reg(input logic [3:0] op);
        case (op)
            OP_LB, OP_LHB, OP_LIM, OP_MVB, OP_MVF,
            OP_ADD, OP_SUB, OP_SFT, OP_INC:        return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer_branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Combinational branch decision for the core sequencer.
// Ports:
//   i_opcode   - latched opcode of the instruction in EXEC
//   i_alu_zero - ALU result == 0
//   i_alu_lt   - ALU signed less-than
//   o_taken    - 1 when the PC must load the jump target in WB
// -----------------------------------------------------------------------------
module branch_resolve
    import core_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_alu_zero,
    input  logic       i_alu_lt,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_opcode)
            OP_JMP:  o_taken = 1'b1;
            OP_BEQ:  o_taken = i_alu_zero;
            OP_BNE:  o_taken = ~i_alu_zero;
            OP_BLT:  o_taken = i_alu_lt;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM for the 8-bit-instruction core. Owns the program
// counter, steps FETCH/DECODE/EXEC/MEM/WB, resolves jumps and branches and
// handshakes with data memory. All strobes are Moore decodes of the state.
//
// Optional feature (macro SEQ_MEM_TIMEOUT_EN): bounds the MEM wait to
// MEM_TIMEOUT cycles; on expiry the core halts and raises sticky mem_err.
//
// Ports:
//   clk, reset         - core clock; asynchronous active-high reset
//   start              - leaves IDLE when high
//   opcode/format      - decoded fields from the instruction ROM
//   jmp_loc            - jump/branch target from the ROM
//   alu_zero/alu_lt    - ALU flags, sampled at the end of EXEC
//   mem_ack            - data memory completion, sampled in MEM
//   pc                 - current PC to the instruction ROM
//   instr_en, alu_en   - FETCH / EXEC strobes
//   mem_req, mem_we    - data memory request and write qualifier
//   rf_we              - register file write strobe (WB)
//   halted, busy       - status
//   mem_err            - sticky memory timeout flag (feature build only)
// -----------------------------------------------------------------------------
module core_sequencer
    import core_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 15
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      opcode,
    input  logic [1:0]      format,
    input  logic [PC_W-1:0] jmp_loc,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            mem_ack,
    output logic [PC_W-1:0] pc,
    output logic            instr_en,
    output logic            alu_en,
    output logic            mem_req,
    output logic            mem_we,
    output logic            rf_we,
    output logic            halted,
    output logic            busy
`ifdef SEQ_MEM_TIMEOUT_EN
    ,
    output logic            mem_err
`endif
);

    seq_state_t      r_state;
    seq_state_t      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_opcode;
    logic            r_taken;
    logic [3:0]      w_dec_op;
    logic            w_taken;
    logic            w_timeout;
    logic            w_unused;

    // An undriven/unknown opcode in DECODE behaves as a NOP (TBA).
    assign w_dec_op = $isunknown(opcode) ? OP_TBA : opcode;

    branch_resolve u_branch_resolve (
        .i_opcode   (r_opcode),
        .i_alu_zero (alu_zero),
        .i_alu_lt   (alu_lt),
        .o_taken    (w_taken)
    );

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_mem_cnt;
    logic             r_mem_err;

    // The counter holds the number of MEM cycles already spent without ack,
    // so the MEM_TIMEOUT-th unacknowledged cycle is the one that expires.
    assign w_timeout = (r_mem_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_cnt <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (r_state != ST_MEM) begin
                r_mem_cnt <= '0;
            end else if (!mem_ack) begin
                r_mem_cnt <= r_mem_cnt + CNT_W'(1);
                if (w_timeout) begin
                    r_mem_err <= 1'b1;
                end
            end
        end
    end

    assign mem_err  = r_mem_err;
    assign w_unused = ^format;
`else
    assign w_timeout = 1'b0;
    assign w_unused  = ^{format, (MEM_TIMEOUT > 0)};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_opcode <= OP_TBA;
            r_taken  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_DECODE) begin
                r_opcode <= w_dec_op;
            end
            if (r_state == ST_EXEC) begin
                r_taken <= w_taken;
            end
            if (r_state == ST_WB) begin
                // PC_W-bit add wraps all-ones to zero naturally.
                r_pc <= r_taken ? jmp_loc : r_pc + PC_W'(1);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        instr_en     = 1'b0;
        alu_en       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        busy         = 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                instr_en     = 1'b1;
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_next = (w_dec_op == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                alu_en       = 1'b1;
                w_state_next = is_mem_op(r_opcode) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_opcode == OP_STR);
                // An ack in the final allowed cycle still wins over timeout.
                if (mem_ack) begin
                    w_state_next = ST_WB;
                end else if (w_timeout) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_WB: begin
                rf_we        = writes_reg(r_opcode);
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                busy   = 1'b0;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign pc = r_pc;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the 8-bit-instruction core. Owns the program counter that addresses the instruction ROM. Consumes the ROM's decoded opcode, format and jump target. Sequences fetch/decode/execute/memory/writeback, resolves jumps and branches, and handshakes with data memory.

Parameters:
PC_W, 16, program counter width; matches ROM address width
RESET_PC, 0, PC value loaded on reset
MEM_TIMEOUT, 15, max cycles waiting for mem_ack (used only with the optional feature)

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level/pulse; leaves IDLE when high
opcode  input  4  decoded opcode from instruction ROM
format  input  2  instruction format (C/I/M/X) from ROM
jmp_loc  input  PC_W  jump/branch target from ROM
alu_zero  input  1  ALU result == 0, valid during EXEC
alu_lt  input  1  ALU signed less-than, valid during EXEC
mem_ack  input  1  data memory completion, sampled in MEM
pc  output  PC_W  current PC to instruction ROM
instr_en  output  1  latch instruction/decode fields
alu_en  output  1  ALU operands/operation valid
mem_req  output  1  data memory request, held until ack
mem_we  output  1  write qualifier for mem_req (STR)
rf_we  output  1  register file write strobe
halted  output  1  core stopped
busy  output  1  state not IDLE and not HALT

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC; all strobes 0, halted=0, busy=0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are registered-state decodes (Moore).
- IDLE: start=1 -> FETCH; else stay.
- FETCH: instr_en=1 for one cycle -> DECODE.
- DECODE: opcode HALT -> HALT. LB, LHB, STR -> EXEC then MEM. Everything else -> EXEC only.
- EXEC: alu_en=1 for one cycle.
  - Memory ops -> MEM.
  - Otherwise -> WB.
  - Latch branch decision in a taken flag:
    - JMP always taken.
    - BEQ taken if alu_zero.
    - BNE taken if !alu_zero.
    - BLT taken if alu_lt.
    - Others never taken.
- MEM: mem_req=1, mem_we=1 only for STR. Stay until mem_ack=1, then -> WB. An ack arriving in the same cycle mem_req first rises is accepted (single-cycle MEM).
- WB: one cycle, then -> FETCH.
  - rf_we=1 for LB, LHB, LIM, MVB, MVF, ADD, SUB, SFT, INC.
  - rf_we=0 for STR, JMP, branches and TBA.
  - PC update: taken -> pc=jmp_loc; else pc=pc+1, wrapping from all-ones to 0.
- HALT: halted=1, busy=0, pc frozen. Exits only via reset. start is ignored.
- TBA executes as a 4-cycle NOP.
- Latency: non-memory instruction = 4 cycles (FETCH..WB). Memory instruction = 5 + extra ack wait cycles.
- mem_ack outside MEM is ignored.
- Reset asserted mid-MEM drops mem_req immediately (asynchronous) and returns to IDLE.
- Format input is informational; control is decoded from opcode only. An X on opcode in DECODE is treated as TBA.

Optional Feature:
Macro SEQ_MEM_TIMEOUT_EN.
- Defined: a counter clears on entering MEM and increments each MEM cycle without ack. If it reaches MEM_TIMEOUT, the FSM goes MEM -> HALT with mem_req dropped and no WB. An extra output port mem_err (1 bit, reset 0) is set and sticky until reset.
- Undefined: no counter, no mem_err port; MEM waits indefinitely.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants (LB..TBA, 4-bit)
  - format constants (C/I/M/X, 2-bit)
  - seq_state_t enum
  - is_mem_op() and writes_reg() functions
- The instruction ROM decoder imports the same package.
- One sub-module, branch_resolve: combinational opcode/alu_zero/alu_lt -> taken. The FSM stays in core_sequencer.

Test Plan:
- Reset then start=1; ADD at pc 0 -> instr_en@cyc1, alu_en@cyc3, rf_we@cyc4, pc 0->1 after 4 cycles.
- JMP with jmp_loc=30 at pc 2 -> pc=30 after WB, rf_we stays 0.
- BEQ at pc 5, jmp_loc=10: alu_zero=1 -> pc=10; repeat with alu_zero=0 -> pc=6. BLT with alu_lt=1 -> pc=jmp_loc.
- STR with mem_ack delayed 3 cycles -> mem_req=1 and mem_we=1 held 4 cycles, rf_we=0, pc+1. LB with immediate ack -> rf_we=1 one cycle after MEM.
- HALT opcode -> halted=1 forever, pc frozen, start toggling ignored. Reset mid-MEM -> mem_req=0 same cycle, pc=RESET_PC.
- With SEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT=15: mem_ack never asserted on LB -> HALT after 15 MEM cycles, mem_err=1, rf_we never asserted. pc=16'hFFFF non-branch -> wraps to 0.
